// File: rtl/lsu_align_unit.sv
// Load/store alignment stage in front of data_memory.
// Aligned accesses pass through; misaligned ones are split into byte beats.
module lsu_align_unit #(
    parameter int SIZE             = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [SIZE-1:0] req_addr,
    input  logic [SIZE-1:0] req_wdata,
    output logic            stall,
    output logic            resp_valid,
    output logic [SIZE-1:0] resp_rdata,
    output logic            misalign_error,
    output logic [SIZE-1:0] mem_address,
    output logic [SIZE-1:0] mem_write_data,
    output logic [1:0]      mem_data_size,
    output logic            mem_extension_type,
    output logic            mem_write_enable,
    input  logic [SIZE-1:0] mem_read_data
);

    typedef enum logic {
        IDLE,
        SPLIT
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] buf_q, buf_d;

    logic        size_legal;
    logic        misaligned;
    logic        reject;
    logic [1:0]  last_beat;
    logic [1:0]  beat;
    logic [7:0]  wbyte;
    logic [15:0] half_merged;
    logic [31:0] word_merged;
    logic [SIZE-1:0] split_rdata;

    assign size_legal = (req_size != 2'b11);

    always_comb begin
        misaligned = 1'b0;
        unique case (req_size)
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    assign reject    = !size_legal || (misaligned && !ALLOW_MISALIGNED);
    assign last_beat = (req_size == 2'b01) ? 2'd1 : 2'd3;
    assign beat      = (state_q == IDLE) ? 2'd0 : cnt_q;

    always_comb begin
        wbyte = 8'h00;
        unique case (beat)
            2'd0: wbyte = req_wdata[7:0];
            2'd1: wbyte = req_wdata[15:8];
            2'd2: wbyte = req_wdata[23:16];
            2'd3: wbyte = req_wdata[31:24];
            default: wbyte = 8'h00;
        endcase
    end

    // Final beat supplies the top byte; earlier bytes come from buf_q.
    assign half_merged = {mem_read_data[7:0], buf_q[7:0]};
    assign word_merged = {mem_read_data[7:0], buf_q[23:0]};

    always_comb begin
        split_rdata = '0;
        if (req_size == 2'b01) begin
            split_rdata = {{(SIZE-16){half_merged[15] & ~req_unsigned}},
                           half_merged};
        end else begin
            split_rdata = SIZE'(word_merged);
        end
    end

    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        buf_d              = buf_q;
        stall              = 1'b0;
        resp_valid         = 1'b0;
        resp_rdata         = '0;
        misalign_error     = 1'b0;
        mem_address        = '0;
        mem_write_data     = '0;
        mem_data_size      = 2'b00;
        mem_extension_type = 1'b0;
        mem_write_enable   = 1'b0;

        if (!rst) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
        end else if (!req_valid) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
        end else if (reject) begin
            misalign_error = 1'b1;
            resp_valid     = 1'b1;
            state_d        = IDLE;
            cnt_d          = 2'd0;
        end else if (!misaligned) begin
            mem_address        = req_addr;
            mem_write_data     = req_wdata;
            mem_data_size      = req_size;
            mem_extension_type = req_unsigned;
            mem_write_enable   = req_write;
            resp_valid         = 1'b1;
            resp_rdata         = req_write ? '0 : mem_read_data;
            state_d            = IDLE;
            cnt_d              = 2'd0;
        end else begin
            mem_address        = req_addr + SIZE'(beat);
            mem_write_data     = SIZE'(wbyte);
            mem_data_size      = 2'b00;
            mem_extension_type = 1'b1;
            mem_write_enable   = req_write;
            if (beat == last_beat) begin
                resp_valid = 1'b1;
                resp_rdata = req_write ? '0 : split_rdata;
                state_d    = IDLE;
                cnt_d      = 2'd0;
            end else begin
                stall   = 1'b1;
                state_d = SPLIT;
                cnt_d   = beat + 2'd1;
                unique case (beat)
                    2'd0: buf_d[7:0]   = mem_read_data[7:0];
                    2'd1: buf_d[15:8]  = mem_read_data[7:0];
                    2'd2: buf_d[23:16] = mem_read_data[7:0];
                    default: buf_d = buf_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            buf_q   <= 24'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: doc/lsu_align_unit.md
Name: lsu_align_unit

Overview:
- Load/store alignment stage that sits directly upstream of data_memory, between the core's execute/memory control and the memory port.
- Aligned accesses pass straight through with zero added latency.
- Misaligned halfword and word accesses are split into sequential byte accesses, using data_memory's byte mode, which supports any offset. The core is stalled during the split; load bytes are merged and then sign- or zero-extended.
- Illegal sizes, and misaligned requests when splitting is disabled, raise an error and no memory access is made.

Parameters:
- SIZE, 32: data and address width.
- ALLOW_MISALIGNED, 1: 1 = split misaligned accesses; 0 = flag them as errors.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  core access request; held stable while stall=1.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- req_unsigned  in  1  0 = sign-extend load, 1 = zero-extend load.
- req_addr  in  SIZE  byte address.
- req_wdata  in  SIZE  store data, right-justified.
- stall  out  1  core must hold the request and not advance.
- resp_valid  out  1  access completes this cycle.
- resp_rdata  out  SIZE  extended load result; 0 for stores.
- misalign_error  out  1  request rejected this cycle.
- mem_address  out  SIZE  to data_memory address.
- mem_write_data  out  SIZE  to data_memory write_data.
- mem_data_size  out  2  to data_memory data_size.
- mem_extension_type  out  1  to data_memory extension_type.
- mem_write_enable  out  1  to data_memory write_enable.
- mem_read_data  in  SIZE  from data_memory read_data (combinational).

Behaviour:
- Misaligned condition:
  - Halfword: req_addr[0]=1.
  - Word: req_addr[1:0]!=00.
  - Byte: never misaligned.
- Aligned request (req_valid=1, legal size, not misaligned):
  - mem_* driven combinationally from req_*.
  - resp_valid=1 the same cycle; stall=0.
  - resp_rdata = mem_read_data for loads, 0 for stores.
- Misaligned request with ALLOW_MISALIGNED=1:
  - N=2 beats for a halfword, N=4 for a word.
  - State: cnt (2-bit), buf (24-bit) holding the earlier load bytes.
  - Beat k (k=cnt) drives:
    - mem_address = req_addr+k, wrapping modulo 2^SIZE.
    - mem_data_size = 00; mem_extension_type = 1.
    - mem_write_data = {24'b0, req_wdata[8k+7:8k]}.
    - mem_write_enable = req_write.
  - For k<N-1:
    - stall=1, resp_valid=0.
    - On posedge: buf byte k <= mem_read_data[7:0]; cnt <= cnt+1.
  - For k=N-1:
    - stall=0, resp_valid=1.
    - Load result is {mem_read_data[7:0], buf bytes N-2..0}, then extended from 8N bits per req_unsigned.
    - On posedge: cnt <= 0.
  - Latency is N cycles; byte order is little-endian, lowest address first.
- FSM states:
  - IDLE (cnt=0): an aligned request completes here; a misaligned one issues beat 0 and moves to SPLIT.
  - SPLIT (cnt>0): issues beat cnt; returns to IDLE after beat N-1.
- Error cases, each lasting one cycle, with cnt unchanged (stays 0):
  - Misaligned request with ALLOW_MISALIGNED=0, or req_size=11: misalign_error=1, mem_write_enable=0, resp_valid=1, resp_rdata=0, stall=0.
- req_valid=0:
  - mem_write_enable=0, resp_valid=0, stall=0, misalign_error=0.
  - If this happens in SPLIT (a core protocol violation), the split is aborted: cnt <= 0 and buf is kept.
- A store split is non-atomic: bytes become visible as each beat's clock edge passes.
- Reset (rst=0, asynchronous):
  - cnt=0, buf=0.
  - All outputs forced to 0 while rst=0, including mem_write_enable, so no write occurs.
  - Reset asserted mid-split aborts the split; the next request starts from beat 0.
- Extension for loads:
  - byte: from bit 7.
  - halfword: from bit 15.
  - word: none.

Test Plan:
- Aligned word and byte: memory word at 0x10 = 0x80FF7F01.
  - LW 0x10 -> resp_valid the same cycle, rdata 0x80FF7F01, stall=0.
  - LB 0x13 -> rdata 0xFFFFFF80; LBU 0x13 -> 0x00000080.
- Misaligned LH 0x11 on that word -> stall=1 for 1 cycle, then resp_valid with rdata 0xFFFFFF7F.
- Misaligned LHU 0x13 with byte 0x14 = 0x12 -> rdata 0x00001280.
- Misaligned SW 0x21 of 0xDEADBEEF:
  - Expect 4 cycles with stall high for 3, byte writes EF/BE/AD/DE to 0x21..0x24.
  - Read back by LW 0x21 -> 0xDEADBEEF in 4 cycles.
  - Bytes 0x20 and 0x25 unchanged.
- ALLOW_MISALIGNED=0, LW 0x02 -> misalign_error=1 for one cycle, mem_write_enable=0, rdata 0.
- req_size=11 -> misalign_error=1 for one cycle, mem_write_enable=0, rdata 0.
- Reset after beat 1 of SW 0x31 -> only bytes 0x31 and 0x32 written, cnt=0, outputs 0.
  - The next LW 0x40 completes in 1 cycle.
